// File: rtl/gol_pkg.sv
// Shared definitions for the generation double-buffer.
package gol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } buf_state_e;

endpackage

// File: rtl/gen_bank.sv
// One DEPTH x WIDTH row bank: single write port, a neighbourhood read (rows ra-1, ra, ra+1)
// with toroidal or dead boundary, and one plain read port.
module gen_bank #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned REGBITS = $clog2(DEPTH),
  parameter int unsigned WRAP    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [REGBITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [REGBITS-1:0] i_ra,
  output logic [WIDTH-1:0]   o_row_a,
  output logic [WIDTH-1:0]   o_row,
  output logic [WIDTH-1:0]   o_row_b,
  input  logic [REGBITS-1:0] i_pa,
  output logic [WIDTH-1:0]   o_pdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Address decode by comparison keeps out-of-range addresses from touching any row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (i_waddr == REGBITS'(i)) r_mem[i] <= i_wdata;
    end
  end

  always_comb begin
    o_row_a = '0;
    o_row   = '0;
    o_row_b = '0;
    o_pdata = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_ra == REGBITS'(i)) begin
        o_row   = r_mem[i];
        o_row_a = (i != 0 || WRAP != 0) ? r_mem[(i + DEPTH - 1) % DEPTH] : '0;
        o_row_b = (i != DEPTH - 1 || WRAP != 0) ? r_mem[(i + 1) % DEPTH] : '0;
      end
      if (i_pa == REGBITS'(i)) o_pdata = r_mem[i];
    end
  end

endmodule

// File: rtl/gen_buffer.sv
// Double-buffered generation store: host loads/clears the current bank, the update engine
// fills the next bank, and a swap publishes it once every row has been written.
module gen_buffer
  import gol_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned REGBITS = $clog2(DEPTH),
  parameter int unsigned WRAP    = 1,
  parameter int unsigned GENBITS = 16
) (
  input  logic               ph2,
  input  logic               reset,
  input  logic               load_en,
  input  logic [REGBITS-1:0] load_addr,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               clear_req,
  output logic               busy,
  input  logic [REGBITS-1:0] ra,
  output logic [WIDTH-1:0]   row_a,
  output logic [WIDTH-1:0]   row,
  output logic [WIDTH-1:0]   row_b,
  input  logic               nxt_we,
  input  logic [REGBITS-1:0] nxt_addr,
  input  logic [WIDTH-1:0]   nxt_data,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic [GENBITS-1:0] gen_count,
  output logic               alive,
  output logic               stable
);

  buf_state_e         r_state, w_state_nxt;
  logic               r_bank_sel;
  logic [DEPTH-1:0]   r_mask;
  logic [REGBITS-1:0] r_clr_cnt;
  logic [GENBITS-1:0] r_gen_count;
  logic               r_swap_ack, r_alive, r_stable, r_nxt_alive, r_nxt_same;

  logic               w_swap, w_mask_full, w_nxt_hit;
  logic               w_cur_we;
  logic [REGBITS-1:0] w_cur_addr;
  logic [WIDTH-1:0]   w_cur_data, w_cur_pdata;
  logic               w_we0, w_we1;
  logic [REGBITS-1:0] w_waddr0, w_waddr1;
  logic [WIDTH-1:0]   w_wdata0, w_wdata1;
  logic [WIDTH-1:0]   w_ra0, w_r0, w_rb0, w_pd0;
  logic [WIDTH-1:0]   w_ra1, w_r1, w_rb1, w_pd1;

  assign w_mask_full = &r_mask;
  assign w_nxt_hit   = nxt_we && ({1'b0, nxt_addr} < (REGBITS + 1)'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
        end else if (swap_req) begin
          if (w_mask_full) w_swap = 1'b1;
          else             w_state_nxt = ST_SWAP_WAIT;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == REGBITS'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      end
      ST_SWAP_WAIT: begin
        if (w_mask_full) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ph2) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // The clear sweep owns the current-bank write port; host loads are dropped meanwhile.
  always_comb begin
    w_cur_we   = load_en;
    w_cur_addr = load_addr;
    w_cur_data = load_data;
    if (r_state == ST_CLEAR) begin
      w_cur_we   = 1'b1;
      w_cur_addr = r_clr_cnt;
      w_cur_data = '0;
    end
  end

  always_comb begin
    w_we0    = w_cur_we;
    w_waddr0 = w_cur_addr;
    w_wdata0 = w_cur_data;
    w_we1    = nxt_we;
    w_waddr1 = nxt_addr;
    w_wdata1 = nxt_data;
    if (r_bank_sel) begin
      w_we0    = nxt_we;
      w_waddr0 = nxt_addr;
      w_wdata0 = nxt_data;
      w_we1    = w_cur_we;
      w_waddr1 = w_cur_addr;
      w_wdata1 = w_cur_data;
    end
  end

  gen_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REGBITS(REGBITS), .WRAP(WRAP)) u_bank0 (
    .i_clk(ph2), .i_rst(reset), .i_we(w_we0), .i_waddr(w_waddr0), .i_wdata(w_wdata0),
    .i_ra(ra), .o_row_a(w_ra0), .o_row(w_r0), .o_row_b(w_rb0),
    .i_pa(nxt_addr), .o_pdata(w_pd0)
  );

  gen_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REGBITS(REGBITS), .WRAP(WRAP)) u_bank1 (
    .i_clk(ph2), .i_rst(reset), .i_we(w_we1), .i_waddr(w_waddr1), .i_wdata(w_wdata1),
    .i_ra(ra), .o_row_a(w_ra1), .o_row(w_r1), .o_row_b(w_rb1),
    .i_pa(nxt_addr), .o_pdata(w_pd1)
  );

  assign w_cur_pdata = r_bank_sel ? w_pd1 : w_pd0;

  // A swap edge wins over a same-edge next write, so that write stays out of the new mask/flags.
  always_ff @(posedge ph2) begin
    if (reset) begin
      r_bank_sel  <= 1'b0;
      r_mask      <= '0;
      r_clr_cnt   <= '0;
      r_gen_count <= '0;
      r_swap_ack  <= 1'b0;
      r_alive     <= 1'b0;
      r_stable    <= 1'b0;
      r_nxt_alive <= 1'b0;
      r_nxt_same  <= 1'b1;
    end else begin
      r_clr_cnt  <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
      r_swap_ack <= w_swap;
      if (w_swap) begin
        r_bank_sel  <= ~r_bank_sel;
        r_mask      <= '0;
        r_gen_count <= r_gen_count + 1'b1;
        r_alive     <= r_nxt_alive;
        r_stable    <= r_nxt_same;
        r_nxt_alive <= 1'b0;
        r_nxt_same  <= 1'b1;
      end else if (w_nxt_hit) begin
        r_mask      <= r_mask | (DEPTH'(1) << nxt_addr);
        r_nxt_alive <= r_nxt_alive | (nxt_data != '0);
        r_nxt_same  <= r_nxt_same & (nxt_data == w_cur_pdata);
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign swap_ack  = r_swap_ack;
  assign gen_count = r_gen_count;
  assign alive     = r_alive;
  assign stable    = r_stable;
  assign row_a     = r_bank_sel ? w_ra1 : w_ra0;
  assign row       = r_bank_sel ? w_r1  : w_r0;
  assign row_b     = r_bank_sel ? w_rb1 : w_rb0;

endmodule

// File: tb/tb_gen_buffer.sv
// Directed bench: one toroidal and one dead-boundary instance (DEPTH=5) driven in lockstep.
module tb_gen_buffer;

  logic       ph2 = 1'b0;
  logic       reset, load_en, clear_req, nxt_we, swap_req;
  logic [2:0] load_addr, nxt_addr, ra;
  logic [7:0] load_data, nxt_data;

  logic        w_busy, w_ack, w_alive, w_stable;
  logic [15:0] w_gen;
  logic [7:0]  w_row_a, w_row, w_row_b;
  logic        d_busy, d_ack, d_alive, d_stable;
  logic [15:0] d_gen;
  logic [7:0]  d_row_a, d_row, d_row_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ph2 = ~ph2;

  gen_buffer #(.WIDTH(8), .DEPTH(5), .REGBITS(3), .WRAP(1), .GENBITS(16)) u_wrap (
    .ph2(ph2), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .clear_req(clear_req), .busy(w_busy), .ra(ra), .row_a(w_row_a), .row(w_row), .row_b(w_row_b),
    .nxt_we(nxt_we), .nxt_addr(nxt_addr), .nxt_data(nxt_data), .swap_req(swap_req),
    .swap_ack(w_ack), .gen_count(w_gen), .alive(w_alive), .stable(w_stable)
  );

  gen_buffer #(.WIDTH(8), .DEPTH(5), .REGBITS(3), .WRAP(0), .GENBITS(16)) u_dead (
    .ph2(ph2), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .clear_req(clear_req), .busy(d_busy), .ra(ra), .row_a(d_row_a), .row(d_row), .row_b(d_row_b),
    .nxt_we(nxt_we), .nxt_addr(nxt_addr), .nxt_data(nxt_data), .swap_req(swap_req),
    .swap_ack(d_ack), .gen_count(d_gen), .alive(d_alive), .stable(d_stable)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph2);
    #1;
  endtask

  task automatic load_row(input logic [2:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic nxt_row(input logic [2:0] a, input logic [7:0] d);
    nxt_we = 1'b1; nxt_addr = a; nxt_data = d;
    tick();
    nxt_we = 1'b0;
  endtask

  task automatic set_ra(input logic [2:0] a);
    ra = a;
    #1;
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; clear_req = 1'b0; nxt_we = 1'b0; swap_req = 1'b0;
    load_addr = '0; nxt_addr = '0; ra = '0; load_data = '0; nxt_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", w_busy, 0);
    chk("rst_gen", w_gen, 0);
    chk("rst_ack", w_ack, 0);
    chk("rst_stable", w_stable, 0);
    chk("rst_row", w_row, 0);

    // neighbourhood reads, both boundary modes
    load_row(0, 8'h01); load_row(1, 8'h02); load_row(2, 8'h04);
    load_row(3, 8'h08); load_row(4, 8'h10);
    set_ra(0);
    chk("wrap_ra0_a", w_row_a, 8'h10);
    chk("wrap_ra0_r", w_row, 8'h01);
    chk("wrap_ra0_b", w_row_b, 8'h02);
    chk("dead_ra0_a", d_row_a, 8'h00);
    chk("dead_ra0_r", d_row, 8'h01);
    set_ra(4);
    chk("wrap_ra4_a", w_row_a, 8'h08);
    chk("wrap_ra4_b", w_row_b, 8'h01);
    chk("dead_ra4_b", d_row_b, 8'h00);
    chk("dead_ra4_r", d_row, 8'h10);
    set_ra(6);
    chk("dead_ra6_a", d_row_a, 0);
    chk("dead_ra6_r", d_row, 0);
    chk("dead_ra6_b", d_row_b, 0);
    chk("wrap_ra6_r", w_row, 0);

    // swap requested with only 3 of 5 rows written
    nxt_row(0, 8'h01); nxt_row(1, 8'h02); nxt_row(2, 8'h04);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("wait_busy", w_busy, 1);
    chk("wait_ack", w_ack, 0);
    nxt_row(3, 8'h08);
    chk("wait_busy4", w_busy, 1);
    nxt_row(4, 8'h10);
    chk("wait_busy5", w_busy, 1);
    chk("wait_ack5", w_ack, 0);
    tick();
    chk("swap1_ack", w_ack, 1);
    chk("swap1_gen", w_gen, 1);
    chk("swap1_busy", w_busy, 0);
    chk("swap1_stable", w_stable, 1);
    chk("swap1_alive", w_alive, 1);
    chk("swap1_gen_dead", d_gen, 1);
    tick();
    chk("swap1_ack_drop", w_ack, 0);
    set_ra(3);
    chk("swap1_row3", w_row, 8'h08);

    // all-zero generation, immediate swap, next write on the swap edge
    for (int i = 0; i < 5; i++) nxt_row(3'(i), 8'h00);
    swap_req = 1'b1; nxt_we = 1'b1; nxt_addr = 3'd2; nxt_data = 8'h55;
    tick();
    swap_req = 1'b0; nxt_we = 1'b0;
    chk("swap2_ack", w_ack, 1);
    chk("swap2_busy", w_busy, 0);
    chk("swap2_gen", w_gen, 2);
    chk("swap2_alive", w_alive, 0);
    chk("swap2_stable", w_stable, 0);
    set_ra(2);
    chk("swap2_row2", w_row, 8'h55);
    set_ra(1);
    chk("swap2_row1", w_row, 8'h00);

    // clear and swap together with a full mask: clear wins, swap dropped
    load_row(0, 8'hAA); load_row(4, 8'hBB);
    for (int i = 0; i < 5; i++) nxt_row(3'(i), 8'h11);
    clear_req = 1'b1; swap_req = 1'b1;
    tick();
    clear_req = 1'b0; swap_req = 1'b0;
    chk("clr_busy1", w_busy, 1);
    chk("clr_ack1", w_ack, 0);
    for (int k = 2; k <= 5; k++) begin
      if (k == 3) begin
        load_en = 1'b1; load_addr = 3'd0; load_data = 8'h77; clear_req = 1'b1;
      end
      tick();
      load_en = 1'b0; clear_req = 1'b0;
      chk($sformatf("clr_busy%0d", k), w_busy, 1);
      chk($sformatf("clr_ack%0d", k), w_ack, 0);
    end
    tick();
    chk("clr_done_busy", w_busy, 0);
    chk("clr_done_gen", w_gen, 2);
    for (int i = 0; i < 5; i++) begin
      set_ra(3'(i));
      chk($sformatf("clr_row%0d", i), w_row, 0);
    end
    tick();
    chk("clr_noswap_ack", w_ack, 0);
    chk("clr_noswap_gen", w_gen, 2);

    // reset in the middle of a clear, with a same-edge load
    load_row(4, 8'h44);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    tick(); tick();
    chk("midclr_busy", w_busy, 1);
    reset = 1'b1; load_en = 1'b1; load_addr = 3'd4; load_data = 8'h99;
    tick();
    reset = 1'b0; load_en = 1'b0;
    chk("rst2_busy", w_busy, 0);
    chk("rst2_gen", w_gen, 0);
    chk("rst2_ack", w_ack, 0);
    chk("rst2_alive", w_alive, 0);
    for (int i = 0; i < 5; i++) begin
      set_ra(3'(i));
      chk($sformatf("rst2_row%0d", i), w_row, 0);
      chk($sformatf("rst2_row_a%0d", i), w_row_a, 0);
    end
    tick();
    chk("rst2_idle", w_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
